cell_scan: RTL and testbench

Display-scan controller that feeds the 7-segment cell decoders. It walks a horizontal window of cells in the ant-farm grid memory, issuing one read per digit. It presents each returned 5-bit cell code to the decoder together with a one-hot digit enable, time-multiplexing a single decoder across the display digits with a programmable dwell. It sits between the grid RAM read port and the per-cell segment decoder.

---
 rtl/cell_scan_pkg.sv | 23 ++
 rtl/cell_scan_dwell_timer.sv | 29 ++
 rtl/cell_scan.sv | 131 +++++++++++++
 tb/tb_cell_scan.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cell_scan_pkg.sv
// Shared definitions for the display-scan controller: cell code layout and scan FSM states.
package cell_scan_pkg;

  localparam logic [2:0] CELL_EMPTY  = 3'd0;
  localparam logic [2:0] CELL_AIR    = 3'd1;
  localparam logic [2:0] CELL_DIRT   = 3'd2;
  localparam logic [2:0] CELL_GROUND = 3'd3;
  localparam logic [2:0] CELL_QUEEN  = 3'd4;
  localparam logic [2:0] CELL_ANT    = 3'd5;
  localparam logic [2:0] CELL_SUGAR  = 3'd6;
  localparam logic [2:0] CELL_TUNNEL = 3'd7;

  localparam int ANT_BIT   = 3;
  localparam int SUGAR_BIT = 4;
  localparam int CODE_W    = SUGAR_BIT + 1;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/cell_scan_dwell_timer.sv
// Loadable down-counter that times how long each digit stays lit; flags when it reaches zero.
module cell_scan_dwell_timer #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cell_scan.sv
// Scans a horizontal window of the grid RAM, one read per digit, and multiplexes the
// returned cell codes onto a single segment decoder with a programmable dwell.
module cell_scan
  import cell_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int COL_W  = 4,
  parameter int ROW_W  = 4,
  parameter int DWELL  = 50000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [COL_W-1:0]       i_view_x,
  input  logic [ROW_W-1:0]       i_view_y,
  output logic [ROW_W+COL_W-1:0] o_mem_addr,
  input  logic [CODE_W-1:0]      i_mem_data,
  output logic [CODE_W-1:0]      o_cell_code,
  output logic [DIGITS-1:0]      o_digit_en,
  output logic                   o_frame_done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic SINGLE_DWELL = (DWELL == 1);

  scan_state_t r_state, w_next_state;

  logic [IDX_W-1:0]       r_idx, w_next_idx;
  logic [COL_W-1:0]       r_col_lat;
  logic [ROW_W-1:0]       r_row_lat;
  logic                   r_started;
  logic [ROW_W+COL_W-1:0] r_mem_addr;
  logic [CODE_W-1:0]      r_cell_code;
  logic [DIGITS-1:0]      r_digit_en;
  logic                   r_frame_done;

  logic             w_load, w_dec, w_leave_show, w_last_show_next;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;

  cell_scan_dwell_timer #(.WIDTH(CNT_W)) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (DWELL_LOAD),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FETCH;
    else          r_state <= w_next_state;
  end

  // The first FETCH after reset only primes the address from the live view.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_leave_show = 1'b0;
    case (r_state)
      FETCH:   if (r_started) w_next_state = CAPTURE;
      CAPTURE: begin
        w_next_state = SHOW;
        w_load       = 1'b1;
      end
      SHOW: begin
        if (w_zero) begin
          w_next_state = FETCH;
          w_leave_show = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_next_state = FETCH;
    endcase
  end

  always_comb begin
    w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    w_last_show_next = (r_idx == LAST_IDX) &&
                       (((r_state == CAPTURE) && SINGLE_DWELL) ||
                        ((r_state == SHOW) && !w_zero && (w_count == CNT_W'(1))));
  end

  // Addresses are registered on entry to FETCH; digit 0 re-samples the view window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started    <= 1'b0;
      r_idx        <= '0;
      r_col_lat    <= '0;
      r_row_lat    <= '0;
      r_mem_addr   <= '0;
      r_cell_code  <= {2'b00, CELL_EMPTY};
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_show_next;
      if ((r_state == FETCH) && !r_started) begin
        r_started  <= 1'b1;
        r_col_lat  <= i_view_x;
        r_row_lat  <= i_view_y;
        r_mem_addr <= {i_view_y, i_view_x};
      end
      if (r_state == CAPTURE) begin
        r_cell_code <= i_mem_data;
        r_digit_en  <= {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
      end
      if (w_leave_show) begin
        r_digit_en <= '0;
        r_idx      <= w_next_idx;
        if (w_next_idx == '0) begin
          r_col_lat  <= i_view_x;
          r_row_lat  <= i_view_y;
          r_mem_addr <= {i_view_y, i_view_x};
        end else begin
          r_mem_addr <= {r_row_lat, r_col_lat + COL_W'(w_next_idx)};
        end
      end
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_cell_code  = r_cell_code;
  assign o_digit_en   = r_digit_en;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_cell_scan.sv
// Directed bench for cell_scan with DIGITS=4, DWELL=3 and a one-cycle-latency grid RAM model.
module tb_cell_scan;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] viewX;
  logic [3:0] viewY;
  logic [7:0] memAddr;
  logic [4:0] memData;
  logic [4:0] cellCode;
  logic [3:0] digitEn;
  logic       frameDone;

  logic [4:0] ramData = 5'd0;
  logic       isolate = 1'b0;
  int         cycIdx  = -1;
  int         checks  = 0;
  int         errors  = 0;

  cell_scan #(.DIGITS(4), .COL_W(4), .ROW_W(4), .DWELL(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_view_x     (viewX),
    .i_view_y     (viewY),
    .o_mem_addr   (memAddr),
    .i_mem_data   (memData),
    .o_cell_code  (cellCode),
    .o_digit_en   (digitEn),
    .o_frame_done (frameDone)
  );

  always #5 clk = ~clk;

  // Grid RAM holds row*16+col truncated to 5 bits, returned one cycle after the address.
  always @(posedge clk) ramData <= memAddr[4:0];

  always @(posedge clk or negedge rstN) begin
    if (!rstN) cycIdx <= -1;
    else       cycIdx <= cycIdx + 1;
  end

  assign memData = (isolate && ((cycIdx % 5) != 1)) ? 5'h1F : ramData;

  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y);
    viewX = x;
    viewY = y;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " addr"}, 16'(memAddr), 16'h0);
    checkOutput({tag, " code"}, 16'(cellCode), 16'h0);
    checkOutput({tag, " en"},   16'(digitEn), 16'h0);
    checkOutput({tag, " done"}, 16'(frameDone), 16'h0);
  endtask

  // addrs packs the four expected digit addresses, digit 0 in the low byte.
  task automatic checkFrame(input string tag, input logic [31:0] addrs,
                            input logic [4:0] prevCode, input int numCycles,
                            input int changeCycle, input logic [3:0] newX,
                            input logic [3:0] newY);
    logic [7:0] expAddr;
    logic [7:0] prevAddr;
    logic [4:0] expCode;
    logic [3:0] expEn;
    logic       expDone;
    int d;
    int p;
    for (int c = 0; c < numCycles; c++) begin
      @(negedge clk);
      d = c / 5;
      p = c % 5;
      expAddr = addrs[d*8 +: 8];
      if (d > 0) prevAddr = addrs[(d-1)*8 +: 8];
      else       prevAddr = {3'b000, prevCode};
      expEn   = (p >= 2) ? (4'b0001 << d) : 4'b0000;
      expCode = (p >= 2) ? expAddr[4:0] : prevAddr[4:0];
      expDone = (c == 19);
      checkOutput($sformatf("%s c%0d addr", tag, c), 16'(memAddr), 16'(expAddr));
      checkOutput($sformatf("%s c%0d en", tag, c), 16'(digitEn), 16'(expEn));
      checkOutput($sformatf("%s c%0d code", tag, c), 16'(cellCode), 16'(expCode));
      checkOutput($sformatf("%s c%0d done", tag, c), 16'(frameDone), 16'(expDone));
      if (c == changeCycle) applyStimulus(newX, newY);
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(4'd2, 4'd1);
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkResetOutputs("reset");

    rstN = 1'b1;
    $display("[TB] first frame after reset, view (2,1)");
    checkFrame("view21", 32'h15141312, 5'd0, 20, 19, 4'd14, 4'd0);

    $display("[TB] horizontal wrap, view (14,0)");
    checkFrame("wrap", 32'h01000F0E, 5'h15, 20, 19, 4'd0, 4'd3);

    $display("[TB] view change during digit 1");
    checkFrame("midchg", 32'h33323130, 5'h01, 20, 6, 4'd5, 4'd3);

    $display("[TB] new view next frame with mem_data isolation");
    isolate = 1'b1;
    checkFrame("isol", 32'h38373635, 5'h13, 20, -1, 4'd0, 4'd0);

    $display("[TB] async reset during digit 2");
    checkFrame("prerst", 32'h38373635, 5'h18, 13, -1, 4'd0, 4'd0);
    rstN = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(negedge clk);
    applyStimulus(4'd9, 4'd2);
    rstN = 1'b1;
    checkFrame("restart", 32'h2C2B2A29, 5'd0, 20, -1, 4'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
